spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 156 +++++++++++++++
 tb/tb_spi_master.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), one byte per transfer, MSB first.
// Each phase is timed in sclk half-periods of CLK_DIV system clocks.
module spi_master #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       ce0
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic [DIV_WIDTH-1:0] LP_CNT_LAST = DIV_WIDTH'(CLK_DIV - 1);

  state_t               r_state, w_state;
  logic [DIV_WIDTH-1:0] r_cnt, w_cnt;
  logic [3:0]           r_half, w_half;
  logic [7:0]           r_tx_sh, w_tx_sh;
  logic [7:0]           r_rx_sh, w_rx_sh;
  logic [7:0]           r_rx_data, w_rx_data;
  logic                 r_sclk, w_sclk;
  logic                 r_mosi, w_mosi;
  logic                 r_ce0, w_ce0;
  logic                 r_busy, w_busy;
  logic                 r_done, w_done;
  logic                 w_tick;

  assign w_tick = (r_cnt == LP_CNT_LAST);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_half    <= '0;
      r_tx_sh   <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_ce0     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_half    <= w_half;
      r_tx_sh   <= w_tx_sh;
      r_rx_sh   <= w_rx_sh;
      r_rx_data <= w_rx_data;
      r_sclk    <= w_sclk;
      r_mosi    <= w_mosi;
      r_ce0     <= w_ce0;
      r_busy    <= w_busy;
      r_done    <= w_done;
    end
  end

  // Every output is computed here one cycle ahead and then registered, so no
  // input reaches a port combinationally.
  always_comb begin
    w_state   = r_state;
    w_cnt     = '0;
    w_half    = r_half;
    w_tx_sh   = r_tx_sh;
    w_rx_sh   = r_rx_sh;
    w_rx_data = r_rx_data;
    w_sclk    = r_sclk;
    w_mosi    = r_mosi;
    w_ce0     = r_ce0;
    w_busy    = r_busy;
    w_done    = 1'b0;

    if (r_state != IDLE && !w_tick) begin
      w_cnt = r_cnt + 1'b1;
    end

    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state = SETUP;
          w_tx_sh = tx_data;
          w_rx_sh = '0;
          w_mosi  = tx_data[7];
          w_sclk  = 1'b0;
          w_half  = '0;
          w_ce0   = 1'b0;
          w_busy  = 1'b1;
        end
      end
      SETUP: begin
        if (w_tick) begin
          w_state = SHIFT;
        end
      end
      SHIFT: begin
        // Even half-periods end in a rise (sample), odd ones in a fall (advance).
        if (w_tick) begin
          w_half = r_half + 4'd1;
          if (!r_sclk) begin
            w_sclk  = 1'b1;
            w_rx_sh = {r_rx_sh[6:0], miso};
          end else begin
            w_sclk = 1'b0;
            if (r_half == 4'd15) begin
              w_state = HOLD;
            end else begin
              w_tx_sh = {r_tx_sh[6:0], 1'b0};
              w_mosi  = r_tx_sh[6];
            end
          end
        end
      end
      HOLD: begin
        if (w_tick) begin
          w_state = GAP;
          w_ce0   = 1'b1;
          w_mosi  = 1'b0;
        end
      end
      GAP: begin
        if (w_tick) begin
          w_state   = IDLE;
          w_rx_data = r_rx_sh;
          w_done    = 1'b1;
          w_busy    = 1'b0;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign rx_data = r_rx_data;
  assign busy    = r_busy;
  assign done    = r_done;
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign ce0     = r_ce0;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: CLK_DIV=4 instance against a mode-0 slave
// model, plus a CLK_DIV=1 instance with miso tied high.
module tb_spi_master;

  localparam int C4   = 4;
  localparam int C1   = 1;
  // Clocks from the cycle presenting start through the done cycle.
  localparam int LAT4 = 19 * C4 + 1;
  localparam int LAT1 = 19 * C1 + 1;

  typedef struct {
    logic [7:0] rx;
    logic [7:0] tx;
    int         done_at;
  } exp_t;

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // CLK_DIV=4 instance
  logic       start4, busy4, done4, sclk4, mosi4, miso4, ce04;
  logic [7:0] tx4, rx4;

  spi_master #(.CLK_DIV(C4), .DIV_WIDTH(8)) u_dut4 (
    .clock(clock), .rst(rst), .start(start4), .tx_data(tx4), .rx_data(rx4),
    .busy(busy4), .done(done4), .sclk(sclk4), .mosi(mosi4), .miso(miso4),
    .ce0(ce04)
  );

  // CLK_DIV=1 instance
  logic       start1, busy1, done1, sclk1, mosi1, ce01;
  logic [7:0] tx1, rx1;

  spi_master #(.CLK_DIV(C1), .DIV_WIDTH(8)) u_dut1 (
    .clock(clock), .rst(rst), .start(start1), .tx_data(tx1), .rx_data(rx1),
    .busy(busy1), .done(done1), .sclk(sclk1), .mosi(mosi1), .miso(1'b1),
    .ce0(ce01)
  );

  // Mode-0 slave: presents MSB at select, samples on rise, shifts on fall,
  // latches the received byte when select is released.
  logic [7:0] slv_out, slv_sh, slv_rx, slv_in;
  always @(negedge ce04) begin
    slv_sh = slv_out;
    miso4  = slv_out[7];
  end
  always @(posedge sclk4) if (!ce04) slv_rx = {slv_rx[6:0], mosi4};
  always @(negedge sclk4) if (!ce04) begin
    slv_sh = {slv_sh[6:0], 1'b0};
    miso4  = slv_sh[7];
  end
  always @(posedge ce04) slv_in = slv_rx;

  exp_t sb4[$];
  int   sb1[$];
  int   free4 = 0;
  logic [7:0] last_rx = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor for the CLK_DIV=4 instance
  int   gap_run = 0;
  exp_t e4;
  always @(negedge clock) begin
    if (ce04) begin
      chk("idle_mosi_low", 32'(mosi4), 32'd0);
      chk("idle_sclk_low", 32'(sclk4), 32'd0);
    end
    if (done4) begin
      if (sb4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done: got done=1 expected no pending transfer (t=%0t)", $time);
      end else begin
        e4 = sb4.pop_front();
        chk("rx_data", 32'(rx4), 32'(e4.rx));
        chk("slave_rx_mosi", 32'(slv_in), 32'(e4.tx));
        chk("done_cycle", 32'(cyc), 32'(e4.done_at));
        chk("ce0_gap_len", 32'(gap_run), 32'(C4));
        chk("busy_at_done", 32'(busy4), 32'd0);
        last_rx = e4.rx;
      end
    end else begin
      chk("rx_data_stable", 32'(rx4), 32'(last_rx));
    end
    if (!busy4) gap_run = 0;
    else if (ce04) gap_run++;
  end

  // Monitor for the CLK_DIV=1 instance
  int   d1;
  int   last_rise = 0;
  bit   rise_ok = 0;
  logic prev1 = 1'b0;
  always @(negedge clock) begin
    if (done1) begin
      if (sb1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_done_div1: got done=1 expected no pending transfer (t=%0t)", $time);
      end else begin
        d1 = sb1.pop_front();
        chk("div1_rx_data", 32'(rx1), 32'hFF);
        chk("div1_done_cycle", 32'(cyc), 32'(d1));
      end
    end
    if (ce01) rise_ok = 0;
    else if (sclk1 && !prev1) begin
      if (rise_ok) chk("div1_sclk_period", 32'(cyc - last_rise), 32'd2);
      rise_ok   = 1;
      last_rise = cyc;
    end
    prev1 = sclk1;
  end

  // Reference model: a request is accepted on the first edge at which start
  // is high and the previous transfer has finished; done follows 19*CLK_DIV
  // edges later, carrying the slave's byte while the slave sees tx.
  task automatic xfer4(input logic [7:0] tx, input logic [7:0] so, input bit hold);
    int   acc;
    exp_t e;
    @(negedge clock);
    start4  = 1'b1;
    tx4     = tx;
    slv_out = so;
    acc = (cyc + 1 > free4) ? cyc + 1 : free4;
    e.rx = so;
    e.tx = tx;
    e.done_at = acc - 1 + LAT4;
    sb4.push_back(e);
    free4 = e.done_at + 1;
    while (cyc < acc) @(negedge clock);
    tx4 = 8'($urandom);
    if (!hold) start4 = 1'b0;
  endtask

  task automatic drain4();
    int n = 0;
    while (sb4.size() > 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (sb4.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain4_timeout: got %0d pending expected 0", sb4.size());
      sb4.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic xfer1();
    int n = 0;
    @(negedge clock);
    start1 = 1'b1;
    tx1    = 8'($urandom);
    sb1.push_back(cyc + LAT1);
    @(negedge clock);
    start1 = 1'b0;
    while (sb1.size() > 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (sb1.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain1_timeout: got %0d pending expected 0", sb1.size());
      sb1.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int   rises;
    bit   found;
    logic prev;
    exp_t dropped;

    rst = 1'b1; start4 = 1'b0; start1 = 1'b0;
    tx4 = '0; tx1 = '0; slv_out = '0; miso4 = 1'b0;
    slv_sh = '0; slv_rx = '0; slv_in = '0;
    #1;
    chk("rst_sclk", 32'(sclk4), 32'd0);
    chk("rst_ce0", 32'(ce04), 32'd1);
    chk("rst_mosi", 32'(mosi4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_rx", 32'(rx4), 32'd0);
    chk("rst_div1_ce0", 32'(ce01), 32'd1);
    chk("rst_div1_rx", 32'(rx1), 32'd0);
    repeat (2) @(negedge clock);
    rst = 1'b0;

    // Basic transfer, then back-to-back with start held high
    xfer4(8'hA5, 8'h3C, 1'b0);
    drain4();
    xfer4(8'hFF, 8'($urandom), 1'b1);
    xfer4(8'h00, 8'($urandom), 1'b0);
    drain4();

    // Start pulses during an active transfer must be ignored
    xfer4(8'h69, 8'($urandom), 1'b0);
    repeat (3) begin
      repeat ($urandom_range(5, 15)) @(negedge clock);
      start4 = 1'b1;
      tx4    = 8'($urandom);
      @(negedge clock);
      start4 = 1'b0;
    end
    drain4();

    // Abort at the 5th sclk rise
    xfer4(8'h96, 8'($urandom), 1'b0);
    rises = 0; found = 0; prev = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clock);
      #1;
      if (sclk4 && !prev) rises++;
      prev = sclk4;
      if (rises == 5) found = 1;
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL fifth_rise_timeout: got %0d rises expected 5", rises);
    end
    last_rx = 8'h00;
    rst = 1'b1;
    #1;
    chk("abort_ce0", 32'(ce04), 32'd1);
    chk("abort_sclk", 32'(sclk4), 32'd0);
    chk("abort_busy", 32'(busy4), 32'd0);
    chk("abort_rx", 32'(rx4), 32'd0);
    dropped = sb4.pop_back();
    free4 = 0;
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1 rst = 1'b0;
    xfer4(8'hC3, 8'h5A, 1'b0);
    drain4();

    // Randomized traffic, some back-to-back
    for (int i = 0; i < 12; i++) begin
      xfer4(8'($urandom), 8'($urandom), (i == 11) ? 1'b0 : 1'($urandom_range(0, 1)));
    end
    drain4();

    // CLK_DIV=1
    repeat (3) xfer1();

    repeat (10) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
